// File: rtl/mips_cpu_mem_arbiter.sv
// Round-robin arbiter sharing one single-port, 1-cycle-latency RAM between the fetch
// and data ports of mips_cpu_harvard. Define MEM_ARB_IBUF_EN for a one-entry fetch buffer.
module mips_cpu_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  instr_read,
  input  logic [ADDR_WIDTH-1:0] instr_address,
  output logic [DATA_WIDTH-1:0] instr_readdata,
  output logic                  instr_waitrequest,
  input  logic                  data_read,
  input  logic                  data_write,
  input  logic [ADDR_WIDTH-1:0] data_address,
  input  logic [DATA_WIDTH-1:0] data_writedata,
  output logic [DATA_WIDTH-1:0] data_readdata,
  output logic                  data_waitrequest,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [DATA_WIDTH-1:0] mem_writedata,
  input  logic [DATA_WIDTH-1:0] mem_readdata,
  output logic                  cpu_clk_enable
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE_I  = 3'd1,
    WAIT_I   = 3'd2,
    ISSUE_DR = 3'd3,
    WAIT_DR  = 3'd4,
    ISSUE_DW = 3'd5
  } state_t;

  state_t                  state_r;
  logic                    last_grant_data_r;
  logic [DATA_WIDTH-1:0]   instr_readdata_r;
  logic [DATA_WIDTH-1:0]   data_readdata_r;
  logic                    ibuf_hit_s;
  logic [DATA_WIDTH-1:0]   ibuf_data_s;
  logic                    instr_pend_s;
  logic                    data_pend_s;
  logic                    grant_instr_s;
  logic                    grant_data_s;
  logic                    instr_done_s;
  logic                    data_done_s;

`ifdef MEM_ARB_IBUF_EN
  logic                    ibuf_valid_r;
  logic [ADDR_WIDTH-1:0]   ibuf_tag_r;
  logic [DATA_WIDTH-1:0]   ibuf_data_r;

  assign ibuf_hit_s  = (state_r == IDLE) && instr_read && ibuf_valid_r && (instr_address == ibuf_tag_r);
  assign ibuf_data_s = ibuf_data_r;

  // Fetch buffer: filled by every RAM fetch, invalidated by a store to the buffered address
  always_ff @(posedge clk) begin
    if (reset) begin
      ibuf_valid_r <= 1'b0;
      ibuf_tag_r   <= '0;
      ibuf_data_r  <= '0;
    end else if (state_r == WAIT_I) begin
      ibuf_valid_r <= 1'b1;
      ibuf_tag_r   <= mem_address;
      ibuf_data_r  <= mem_readdata;
    end else if (grant_data_s && data_write && (data_address == ibuf_tag_r)) begin
      ibuf_valid_r <= 1'b0;
    end else begin
      ibuf_valid_r <= ibuf_valid_r;
    end
  end
`else
  assign ibuf_hit_s  = 1'b0;
  assign ibuf_data_s = '0;
`endif

  // Grant decision and per-port handshake; a buffer hit leaves the RAM free for data
  always_comb begin
    instr_pend_s      = instr_read && !ibuf_hit_s;
    data_pend_s       = data_read || data_write;
    grant_instr_s     = (state_r == IDLE) && instr_pend_s && (!data_pend_s || last_grant_data_r);
    grant_data_s      = (state_r == IDLE) && data_pend_s && !grant_instr_s;
    instr_done_s      = !reset && ((state_r == WAIT_I) || ibuf_hit_s);
    data_done_s       = !reset && ((state_r == WAIT_DR) || (state_r == ISSUE_DW));
    instr_waitrequest = instr_read && !instr_done_s;
    data_waitrequest  = data_pend_s && !data_done_s;
    cpu_clk_enable    = !(instr_waitrequest || data_waitrequest);
    if (state_r == WAIT_I) begin
      instr_readdata = mem_readdata;
    end else if (ibuf_hit_s) begin
      instr_readdata = ibuf_data_s;
    end else begin
      instr_readdata = instr_readdata_r;
    end
    if (state_r == WAIT_DR) begin
      data_readdata = mem_readdata;
    end else begin
      data_readdata = data_readdata_r;
    end
  end

  // Arbitration FSM with registered RAM address, strobes and write data
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r           <= IDLE;
      last_grant_data_r <= 1'b1;
      mem_read          <= 1'b0;
      mem_write         <= 1'b0;
      mem_address       <= '0;
      mem_writedata     <= '0;
      instr_readdata_r  <= '0;
      data_readdata_r   <= '0;
    end else begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      case (state_r)
        IDLE: begin
          if (grant_instr_s) begin
            mem_address       <= instr_address;
            mem_read          <= 1'b1;
            last_grant_data_r <= 1'b0;
            state_r           <= ISSUE_I;
          end else if (grant_data_s) begin
            mem_address       <= data_address;
            last_grant_data_r <= 1'b1;
            if (data_write) begin
              mem_write     <= 1'b1;
              mem_writedata <= data_writedata;
              state_r       <= ISSUE_DW;
            end else begin
              mem_read <= 1'b1;
              state_r  <= ISSUE_DR;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        ISSUE_I:  state_r <= WAIT_I;
        ISSUE_DR: state_r <= WAIT_DR;
        ISSUE_DW: state_r <= IDLE;
        WAIT_I: begin
          instr_readdata_r <= mem_readdata;
          state_r          <= IDLE;
        end
        WAIT_DR: begin
          data_readdata_r <= mem_readdata;
          state_r         <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule
